aes_key_expand: RTL and testbench

- AES-128 key-schedule stage, directly upstream of the AES core.
- Consumes the 128-bit key shifted in over SPI and produces the 11 round keys (round 0..10) one at a time.
- Uses a start/advance handshake, so the core never stores the full expanded schedule.
- Computes one round key per consumed key; needs 4 S-box lookups per round instead of the core's 16.

---
 rtl/aes_pkg.sv | 26 ++
 rtl/aes_key_expand_if.sv | 23 ++
 rtl/aes_sbox.sv | 34 +++
 rtl/aes_key_expand.sv | 118 +++++++++++
 tb/tb_aes_key_expand.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule and the cipher core:
// schedule constants, the 32-bit word type, the GF(2^8) doubling and the
// word rotation used by the key expansion.
package aes_pkg;

  localparam int NK = 4;   // key length in 32-bit words (AES-128)
  localparam int NR = 10;  // number of rounds (AES-128)

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Cyclic left rotation by one byte: [a,b,c,d] -> [b,c,d,a].
  function automatic word_t rotword(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Handshake and data bundle between the AES core (master) and the
// key-schedule stage (slave).
interface aes_key_expand_if;

  logic         start;      // one-cycle pulse: latch key, restart at round 0
  logic [127:0] key;        // cipher key, w0 in [127:96]
  logic         advance;    // current round key consumed, produce the next
  logic [127:0] round_key;  // current round key, same word order as key
  logic [3:0]   round_idx;  // index of round_key, 0..10
  logic         key_valid;  // round_key / round_idx are meaningful
  logic         last;       // key_valid and final round

  modport master (
    output start, key, advance,
    input  round_key, round_idx, key_valid, last
  );

  modport slave (
    input  start, key, advance,
    output round_key, round_idx, key_valid, last
  );

endinterface

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box as a purely combinational 256-entry lookup.
// Shared between the key schedule (SubWord) and the cipher core (SubBytes).
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry 0x00 sits in the top byte, entry 0xff in the bottom byte.
  localparam logic [2047:0] LUT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry n lives at bit offset 8*(255-n); 255-n is simply ~n.
  logic [10:0] base;

  assign base = {~din, 3'b000};
  assign dout = LUT[base +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule, one round key at a time.
// A start pulse loads the cipher key as round key 0; each advance replaces
// the held round key with the next one, so only a single 128-bit key, the
// round counter and the current rcon are ever stored. After round 10 is
// consumed the block returns to IDLE and holds its last outputs.
module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             reset,
  aes_key_expand_if.slave  bus
);

  import aes_pkg::*;

  if (NR != aes_pkg::NR) begin : g_nr_check
    $error("aes_key_expand: only NR = 10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t       state;
  state_t       state_nxt;
  logic         load;
  logic         step;

  logic [127:0] rk_p0;
  logic [3:0]   idx_p0;
  logic [7:0]   rcon_p0;
  logic         vld_p0;

  word_t        w0, w1, w2, w3;
  word_t        rot;
  word_t        sub;
  word_t        t;
  word_t        n0, n1, n2, n3;

  // ---- combinational next-round-key logic from the held key ----
  assign w0  = rk_p0[127:96];
  assign w1  = rk_p0[95:64];
  assign w2  = rk_p0[63:32];
  assign w3  = rk_p0[31:0];
  assign rot = rotword(w3);

  for (genvar i = 0; i < NK; i++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot[8*i +: 8]),
      .dout (sub[8*i +: 8])
    );
  end

  assign t  = sub ^ {rcon_p0, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // Next-state decode: start always wins (restart), advance only acts in RUN.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.start) begin
          load = 1'b1;
        end else if (bus.advance) begin
          if (idx_p0 == LAST_IDX) begin
            state_nxt = IDLE;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- stage p0: held round key, its index and the rcon for the next round ----
  // Round-key register: reload on start, step forward on advance, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_p0   <= '0;
      idx_p0  <= '0;
      rcon_p0 <= 8'h01;
    end else if (load) begin
      rk_p0   <= bus.key;
      idx_p0  <= '0;
      rcon_p0 <= 8'h01;
    end else if (step) begin
      rk_p0   <= {n0, n1, n2, n3};
      idx_p0  <= idx_p0 + 4'd1;
      rcon_p0 <= xtime(rcon_p0);
    end
  end

  assign vld_p0        = (state == RUN);
  assign bus.round_key = rk_p0;
  assign bus.round_idx = idx_p0;
  assign bus.key_valid = vld_p0;
  assign bus.last      = vld_p0 && (idx_p0 == LAST_IDX);

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: directed known-answer scenarios plus random
// start/advance traffic, compared every cycle against a word-level
// FIPS-197 key expansion with an arithmetically derived S-box.
module tb_aes_key_expand;

  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K1_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk;
  logic reset;

  aes_key_expand_if bus ();

  aes_key_expand dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0]   tb_sbox [256];
  logic [127:0] m_sched [11];
  int           m_idx;
  bit           m_valid;
  bit           m_started;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                 ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Classic 44-word expansion loop, regrouped into 11 round keys.
  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {tb_sbox[tmp[31:24]], tb_sbox[tmp[23:16]], tb_sbox[tmp[15:8]], tb_sbox[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      m_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_reset();
    m_idx     = 0;
    m_valid   = 0;
    m_started = 0;
  endtask

  task automatic check_all(input string tag);
    logic [127:0] exp_rk;
    exp_rk = m_started ? m_sched[m_idx] : '0;
    check_eq({tag, ".rk"},   bus.round_key, exp_rk);
    check_eq({tag, ".idx"},  128'(bus.round_idx), 128'(m_idx));
    check_eq({tag, ".vld"},  128'(bus.key_valid), 128'(m_valid));
    check_eq({tag, ".last"}, 128'(bus.last), 128'(m_valid && m_idx == 10));
  endtask

  // One clock: apply inputs, advance the model at the edge, check after it.
  task automatic step(input logic s, input logic a, input logic [127:0] k, input string tag);
    bus.start   = s;
    bus.advance = a;
    bus.key     = k;
    @(posedge clk);
    if (s) begin
      build_model(k);
      m_idx     = 0;
      m_valid   = 1;
      m_started = 1;
    end else if (a && m_valid) begin
      if (m_idx < 10) m_idx++;
      else m_valid = 0;
    end
    #1;
    bus.start   = 1'b0;
    bus.advance = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [127:0] rkey;
    model_reset();
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.advance = 1'b0;
    bus.key     = '0;
    build_sbox();
    @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    // Back-to-back schedule with known answers.
    step(1, 0, K1, "t1.start");
    check_eq("t1.r0", bus.round_key, K1);
    step(0, 1, K1, "t1.adv");
    check_eq("t1.r1", bus.round_key, K1_R1);
    step(0, 1, K1, "t1.adv");
    check_eq("t1.r2", bus.round_key, K1_R2);
    for (int i = 3; i <= 10; i++) step(0, 1, K1, "t1.adv");
    check_eq("t1.r10", bus.round_key, K1_RA);
    check_eq("t1.last", 128'(bus.last), 128'(1));
    step(0, 1, K1, "t1.end");
    check_eq("t1.done", 128'(bus.key_valid), 128'(0));

    // Advance with random idle gaps; outputs must hold in between.
    step(1, 0, K2, "t2.start");
    for (int r = 0; r < 10; r++) begin
      int gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) step(0, 0, K2, "t2.gap");
      step(0, 1, K2, "t2.adv");
    end
    check_eq("t2.r10", bus.round_key, K2_RA);
    step(0, 1, K2, "t2.end");

    // Restart at round 4 with advance also asserted.
    step(1, 0, K1, "t3.start");
    for (int i = 0; i < 4; i++) step(0, 1, K1, "t3.adv");
    step(1, 1, K2, "t3.restart");
    check_eq("t3.idx0", 128'(bus.round_idx), 128'(0));
    check_eq("t3.r0", bus.round_key, K2);
    for (int i = 0; i < 10; i++) step(0, 1, K2, "t3.adv");
    check_eq("t3.r10", bus.round_key, K2_RA);

    // Asynchronous reset in the middle of a schedule.
    step(1, 0, K2, "t4.start");
    for (int i = 0; i < 6; i++) step(0, 1, K2, "t4.adv");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("t4.rst.rk",  bus.round_key, 128'(0));
    check_eq("t4.rst.idx", 128'(bus.round_idx), 128'(0));
    check_eq("t4.rst.vld", 128'(bus.key_valid), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, K1, "t4.start2");
    for (int i = 0; i < 10; i++) step(0, 1, K1, "t4.adv2");
    check_eq("t4.r10", bus.round_key, K1_RA);
    step(0, 1, K1, "t4.end");

    // IDLE: advance pulses and key changes without start do nothing.
    for (int i = 0; i < 5; i++) begin
      rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(0, 1, rkey, "t5.idle");
    end
    check_eq("t5.vld", 128'(bus.key_valid), 128'(0));
    check_eq("t5.hold", bus.round_key, K1_RA);

    // Start together with the final advance: restart wins.
    step(1, 0, K1, "t6.start");
    for (int i = 0; i < 10; i++) step(0, 1, K1, "t6.adv");
    step(1, 1, K1, "t6.restart");
    check_eq("t6.vld", 128'(bus.key_valid), 128'(1));
    check_eq("t6.idx", 128'(bus.round_idx), 128'(0));
    step(0, 1, K1, "t6.adv");
    check_eq("t6.r1", bus.round_key, K1_R1);

    // Random traffic: sparse restarts, random advance, key wiggling.
    for (int i = 0; i < 400; i++) begin
      rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), rkey, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
